fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the PC loaded on reset; bits [1:0] shall be 00.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 stall  input  1  hazard unit hold request; freezes the PC and the IF/ID outputs.
REQ-005 flush  input  1  hazard unit kill request; turns the IF/ID slot into a bubble.
REQ-006 pcsrc  input  1  redirect request; the next fetch comes from pctarget.
REQ-007 pctarget  input  32  branch/jump target from execute.
REQ-008 imem_req  output  1  instruction memory read request.
REQ-009 imem_addr  output  32  read address; equals the fetch PC.
REQ-010 imem_valid  input  1  read data valid; the response to the single outstanding request.
REQ-011 imem_rdata  input  32  instruction word.
REQ-012 instr_d  output  32  IF/ID instruction; bits [31:7] feed the immediate extender.
REQ-013 pc_d, pcplus4_d  output  32 each  IF/ID PC and PC+4.
REQ-014 valid_d  output  1  IF/ID slot holds a real instruction.
REQ-015 misalign  output  1  sticky misaligned-target flag; constant 0 when the feature is compiled out.

Function
REQ-016 States: S_REQ (imem_req=1), S_HOLD (response buffered, imem_req=0), S_DROP (stale response pending, imem_req=0), S_HALT (macro only, imem_req=0).
REQ-017 At most one request is outstanding; imem_addr shall stay stable while imem_req=1 and imem_valid=0.
REQ-018 imem_valid shall be ignored in S_HOLD and S_HALT.
REQ-019 S_REQ with imem_valid=1 and stall=0: the IF/ID register loads {imem_rdata, pcf, pcf+4} and sets valid_d=1; pcf advances to pcf+4 (pctarget if pcsrc=1); the state stays S_REQ; the next request issues the following cycle or later.
REQ-020 S_REQ with imem_valid=1 and stall=1: the word and its PC are captured in a one-entry hold buffer; the state goes to S_HOLD.
REQ-021 S_HOLD with stall=0: the hold buffer transfers to IF/ID in that cycle; pcf advances; the state goes to S_REQ.
REQ-022 pcsrc=1 in any non-halt state: pcf takes pctarget at the next edge, whatever stall is; the hold buffer is discarded.
REQ-023 pcsrc=1 while a request is outstanding and imem_valid=0: the state goes to S_DROP; the eventual response is discarded; the state then goes to S_REQ at pctarget.
REQ-024 flush=1: at the next edge, valid_d=0 and instr_d=NOP (32'h0000_0013); flush has priority over the stall hold and over a load.
REQ-025 stall=1 and flush=0: instr_d, pc_d, pcplus4_d and valid_d shall hold their values.
REQ-026 PC arithmetic is modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
REQ-027 Fetch latency: a memory with zero-wait response gives one IF/ID load per two cycles; instr_d updates on the edge after imem_valid.

Reset
REQ-028 While reset=1: pcf=RESET_PC, state=S_REQ, imem_req=0, valid_d=0, instr_d=NOP, pc_d=0, pcplus4_d=0, misalign=0, hold buffer empty.
REQ-029 Reset mid-request abandons the outstanding request; any response arriving before the first post-reset request shall be ignored.
REQ-030 The first request issues in the cycle after reset deasserts, with imem_addr=RESET_PC.

Configuration
REQ-031 Macro FETCH_MISALIGN_EN defined: when pcsrc=1 and pctarget[1:0]!=00, misalign=1 (sticky until reset), the state goes to S_HALT, no further requests issue, and valid_d=0.
REQ-032 Macro FETCH_MISALIGN_EN undefined: pctarget[1:0] is forced to 00 on redirect, misalign is tied to 0, and S_HALT does not exist.

Structure
REQ-033 Package riscv_pkg holds the NOP constant, the fetch state enum and the RESET_PC default.
REQ-034 Sub-module ifid_reg holds the IF/ID register with its stall, flush and load controls; fetch_stage holds the PC, the FSM and the hold buffer.

Verification
REQ-035 Reset with RESET_PC=0x100 and zero-wait memory -> imem_addr sequence 0x100, 0x104, 0x108; pc_d follows one load behind.
REQ-036 Memory with 3-cycle latency at 0x200 -> imem_addr stays 0x200 for all 3 cycles; instr_d=rdata on the edge after imem_valid.
REQ-037 stall=1 when the response arrives -> S_HOLD, imem_req=0; stall released -> instr_d loads the buffered word; the next imem_addr=PC+4.
REQ-038 pcsrc=1 with pctarget=0x400 while waiting -> S_DROP; the stale response is discarded; the next request is at 0x400; valid_d is never set for the stale word.
REQ-039 flush=1 together with stall=1 -> next cycle valid_d=0 and instr_d=0x00000013.
REQ-040 With FETCH_MISALIGN_EN defined, pctarget=0x402 -> misalign=1 and imem_req stays 0 until reset; with it undefined -> fetch proceeds from 0x400.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage definitions: NOP encoding, reset PC default and FSM states.
// S_HALT is only present when FETCH_MISALIGN_EN is defined.
package riscv_pkg;

  localparam logic [31:0] NOP              = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

`ifdef FETCH_MISALIGN_EN
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_HOLD = 2'd1,
    S_DROP = 2'd2,
    S_HALT = 2'd3
  } fetch_state_e;
`else
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_HOLD = 2'd1,
    S_DROP = 2'd2
  } fetch_state_e;
`endif

  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory read port: level request held until the single response arrives.
interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_valid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_valid,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline register. Priority: flush, then load, then stall hold, else bubble.
module ifid_reg
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        load,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pcplus4_d,
  output logic        valid_d
);

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_d   <= NOP;
      pc_d      <= 32'd0;
      pcplus4_d <= 32'd0;
      valid_d   <= 1'b0;
    end else if (flush) begin
      instr_d <= NOP;
      valid_d <= 1'b0;
    end else if (load) begin
      instr_d   <= instr;
      pc_d      <= pc;
      pcplus4_d <= pc_plus4(pc);
      valid_d   <= 1'b1;
    end else if (!stall) begin
      // Decode consumed the slot and nothing new arrived: present a bubble.
      instr_d <= NOP;
      valid_d <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: PC, request FSM and one-entry hold buffer feeding the IF/ID register.
// Optional macro FETCH_MISALIGN_EN enables misaligned-redirect detection and S_HALT.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  logic          flush,
  input  logic          pcsrc,
  input  logic [31:0]   pctarget,
  fetch_stage_if.master imem,
  output logic [31:0]   instr_d,
  output logic [31:0]   pc_d,
  output logic [31:0]   pcplus4_d,
  output logic          valid_d,
  output logic          misalign
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pcf_q, pcf_d;
  logic [31:0]  hold_instr_q, hold_instr_d;
  logic [31:0]  hold_pc_q, hold_pc_d;
  logic         gap_q, gap_d;
  logic [31:0]  target;
  logic         req_active;
  logic         load;
  logic         kill;
  logic [31:0]  load_instr;
  logic [31:0]  load_pc;

`ifdef FETCH_MISALIGN_EN
  logic misalign_q, misalign_d;
  logic halt_enter;

  assign target     = pctarget;
  assign halt_enter = pcsrc && (pctarget[1:0] != 2'b00) && (state_q != S_HALT);
  assign misalign   = misalign_q;
  assign kill       = flush || (state_d == S_HALT);
`else
  assign target   = pctarget & 32'hFFFF_FFFC;
  assign misalign = 1'b0;
  assign kill     = flush;
`endif

  // gap_q inserts one idle cycle after a direct load so each request starts cleanly.
  assign imem.imem_req  = (state_q == S_REQ) && !gap_q && !reset;
  assign imem.imem_addr = pcf_q;
  assign req_active     = imem.imem_req;

  always_comb begin
    state_d      = state_q;
    pcf_d        = pcf_q;
    gap_d        = 1'b0;
    hold_instr_d = hold_instr_q;
    hold_pc_d    = hold_pc_q;
    load         = 1'b0;
    load_instr   = imem.imem_rdata;
    load_pc      = pcf_q;
`ifdef FETCH_MISALIGN_EN
    misalign_d   = misalign_q;
`endif

    case (state_q)
      S_REQ: begin
        if (req_active && imem.imem_valid) begin
          if (!stall) begin
            load  = 1'b1;
            pcf_d = pcsrc ? target : pc_plus4(pcf_q);
            gap_d = 1'b1;
          end else if (pcsrc) begin
            pcf_d = target;
          end else begin
            hold_instr_d = imem.imem_rdata;
            hold_pc_d    = pcf_q;
            state_d      = S_HOLD;
          end
        end else if (pcsrc) begin
          pcf_d = target;
          // An unanswered request is still in flight; its response must be dropped.
          if (req_active) begin
            state_d = S_DROP;
          end
        end
      end

      S_HOLD: begin
        if (pcsrc) begin
          pcf_d   = target;
          state_d = S_REQ;
        end else if (!stall) begin
          load       = 1'b1;
          load_instr = hold_instr_q;
          load_pc    = hold_pc_q;
          pcf_d      = pc_plus4(hold_pc_q);
          state_d    = S_REQ;
        end
      end

      S_DROP: begin
        if (pcsrc) begin
          pcf_d = target;
        end
        if (imem.imem_valid) begin
          state_d = S_REQ;
        end
      end

`ifdef FETCH_MISALIGN_EN
      S_HALT: begin
      end
`endif

      default: state_d = S_REQ;
    endcase

`ifdef FETCH_MISALIGN_EN
    if (halt_enter) begin
      state_d    = S_HALT;
      pcf_d      = pcf_q;
      load       = 1'b0;
      gap_d      = 1'b0;
      misalign_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_REQ;
      pcf_q        <= RESET_PC;
      gap_q        <= 1'b0;
      hold_instr_q <= 32'd0;
      hold_pc_q    <= 32'd0;
    end else begin
      state_q      <= state_d;
      pcf_q        <= pcf_d;
      gap_q        <= gap_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
    end
  end

`ifdef FETCH_MISALIGN_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end
`endif

  ifid_reg u_ifid (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .flush     (kill),
    .load      (load),
    .instr     (load_instr),
    .pc        (load_pc),
    .instr_d   (instr_d),
    .pc_d      (pc_d),
    .pcplus4_d (pcplus4_d),
    .valid_d   (valid_d)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, hand sequences for
// multi-cycle corners, then randomized traffic against a behavioural model.
module tb_fetch_stage;

  localparam logic [31:0] RPC    = 32'h0000_0100;
  localparam logic [31:0] TB_NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        pcsrc = 1'b0;
  logic [31:0] pctarget = 32'd0;
  logic [31:0] instr_d, pc_d, pcplus4_d;
  logic        valid_d, misalign;

  fetch_stage_if bus ();

  fetch_stage #(.RESET_PC(RPC)) dut (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .flush     (flush),
    .pcsrc     (pcsrc),
    .pctarget  (pctarget),
    .imem      (bus),
    .instr_d   (instr_d),
    .pc_d      (pc_d),
    .pcplus4_d (pcplus4_d),
    .valid_d   (valid_d),
    .misalign  (misalign)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
  endfunction

  // Memory: answers the outstanding request after m_lat cycles (1 = same cycle).
  int          lat_fixed = 1;
  bit          lat_rand = 1'b0;
  int          m_lat = 1;
  int          m_age = 0;
  logic        m_pend = 1'b0;
  logic [31:0] m_addr = 32'd0;
  logic        m_active;
  logic [31:0] m_cur;

  assign m_active       = bus.imem_req || m_pend;
  assign m_cur          = m_pend ? m_addr : bus.imem_addr;
  assign bus.imem_valid = m_active && (m_age >= m_lat - 1);
  assign bus.imem_rdata = bus.imem_valid ? word_of(m_cur) : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    if (reset) begin
      m_pend <= 1'b0;
      m_age  <= 0;
      m_lat  <= lat_rand ? int'($urandom_range(4, 1)) : lat_fixed;
    end else if (bus.imem_valid) begin
      m_pend <= 1'b0;
      m_age  <= 0;
      m_lat  <= lat_rand ? int'($urandom_range(4, 1)) : lat_fixed;
    end else if (m_active) begin
      if (!m_pend) m_addr <= bus.imem_addr;
      m_pend <= 1'b1;
      m_age  <= m_age + 1;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input int lat, input bit rnd);
    lat_fixed = lat;
    lat_rand  = rnd;
    reset     = 1'b1;
    stall     = 1'b0;
    flush     = 1'b0;
    pcsrc     = 1'b0;
    pctarget  = 32'd0;
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic wait_req(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (bus.imem_req) break;
      tick();
    end
    check1(name, bus.imem_req, 1'b1);
  endtask

  task automatic wait_resp(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (bus.imem_req && bus.imem_valid) break;
      tick();
    end
    check1(name, bus.imem_req && bus.imem_valid, 1'b1);
  endtask

  // Behavioural model state for the random phase.
  logic [31:0] r_pc;
  bit          r_discard, r_cool;
  logic [31:0] r_buf[$];
  logic        e_valid;
  logic [31:0] e_instr, e_pc, e_pc4;

  function automatic bit model_req();
    return !r_cool && !r_discard && (r_buf.size() == 0);
  endfunction

  task automatic model_reset;
    r_pc      = RPC;
    r_discard = 1'b0;
    r_cool    = 1'b0;
    r_buf.delete();
    e_valid   = 1'b0;
    e_instr   = TB_NOP;
    e_pc      = 32'd0;
    e_pc4     = 32'd0;
  endtask

  task automatic model_step(input logic v, input logic [31:0] rd);
    bit          ld = 1'b0;
    bit          cool_n = 1'b0;
    logic [31:0] li = 32'd0;
    logic [31:0] lp = 32'd0;
    logic [31:0] tgt = pctarget & 32'hFFFF_FFFC;
    bit          rq = model_req();
    if (r_discard) begin
      if (pcsrc) r_pc = tgt;
      if (v) r_discard = 1'b0;
    end else if (r_buf.size() != 0) begin
      if (pcsrc) begin
        r_buf.delete();
        r_pc = tgt;
      end else if (!stall) begin
        ld = 1'b1;
        li = r_buf.pop_front();
        lp = r_pc;
        r_pc = r_pc + 32'd4;
      end
    end else if (rq && v) begin
      if (!stall) begin
        ld = 1'b1;
        li = rd;
        lp = r_pc;
        r_pc = pcsrc ? tgt : r_pc + 32'd4;
        cool_n = 1'b1;
      end else if (pcsrc) begin
        r_pc = tgt;
      end else begin
        r_buf.push_back(rd);
      end
    end else if (pcsrc) begin
      r_pc = tgt;
      if (rq) r_discard = 1'b1;
    end
    r_cool = cool_n;
    if (flush) begin
      e_valid = 1'b0;
      e_instr = TB_NOP;
    end else if (ld) begin
      e_valid = 1'b1;
      e_instr = li;
      e_pc    = lp;
      e_pc4   = lp + 32'd4;
    end else if (!stall) begin
      e_valid = 1'b0;
      e_instr = TB_NOP;
    end
  endtask

  typedef struct {
    logic        st;
    logic        fl;
    logic        pc;
    logic [31:0] tgt;
    int          lat;
    logic        exp_valid;
    logic [31:0] exp_instr;
    logic [31:0] exp_pc;
    logic [31:0] exp_next;
  } vec_t;

  localparam int NV = 9;
  vec_t vecs[NV];

  initial begin
    logic [31:0] w100;
    w100 = word_of(RPC);
    // Controls applied in the cycle the first response (at RESET_PC) arrives.
    vecs[0] = '{1'b0, 1'b0, 1'b0, 32'h0,         1, 1'b1, w100,   RPC,   RPC + 32'd4};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 32'h0,         1, 1'b0, TB_NOP, 32'h0, RPC + 32'd4};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 32'h400,       1, 1'b1, w100,   RPC,   32'h400};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 32'h0,         1, 1'b0, TB_NOP, 32'h0, RPC + 32'd4};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 32'h0,         1, 1'b0, TB_NOP, 32'h0, RPC + 32'd4};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 32'h400,       1, 1'b0, TB_NOP, 32'h0, 32'h400};
    vecs[6] = '{1'b0, 1'b1, 1'b1, 32'h800,       3, 1'b0, TB_NOP, 32'h0, 32'h800};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 32'h0,         3, 1'b1, w100,   RPC,   RPC + 32'd4};
    vecs[8] = '{1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 2, 1'b1, w100,   RPC,   32'hFFFF_FFFC};

    for (int i = 0; i < NV; i++) begin
      do_reset(vecs[i].lat, 1'b0);
      wait_resp($sformatf("v%0d_resp", i), 10);
      stall    = vecs[i].st;
      flush    = vecs[i].fl;
      pcsrc    = vecs[i].pc;
      pctarget = vecs[i].tgt;
      tick();
      stall = 1'b0;
      flush = 1'b0;
      pcsrc = 1'b0;
      check1($sformatf("v%0d_valid", i), valid_d, vecs[i].exp_valid);
      check($sformatf("v%0d_instr", i), instr_d, vecs[i].exp_instr);
      check($sformatf("v%0d_pc", i), pc_d, vecs[i].exp_pc);
      check($sformatf("v%0d_pc4", i), pcplus4_d,
            vecs[i].exp_valid ? vecs[i].exp_pc + 32'd4 : 32'h0);
      wait_req($sformatf("v%0d_nreq", i), 10);
      check($sformatf("v%0d_naddr", i), bus.imem_addr, vecs[i].exp_next);
    end

    // Reset values, then zero-wait sequential fetch at one load per two cycles.
    lat_fixed = 1;
    lat_rand  = 1'b0;
    reset     = 1'b1;
    tick();
    tick();
    check1("rst_req", bus.imem_req, 1'b0);
    check1("rst_valid", valid_d, 1'b0);
    check("rst_instr", instr_d, TB_NOP);
    check("rst_pc", pc_d, 32'h0);
    check("rst_pc4", pcplus4_d, 32'h0);
    check1("rst_misalign", misalign, 1'b0);
    reset = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      check1($sformatf("seq%0d_req", k), bus.imem_req, 1'b1);
      check($sformatf("seq%0d_addr", k), bus.imem_addr, RPC + 32'(4 * k));
      tick();
      check($sformatf("seq%0d_pc", k), pc_d, RPC + 32'(4 * k));
      check($sformatf("seq%0d_pc4", k), pcplus4_d, RPC + 32'(4 * k + 4));
      check($sformatf("seq%0d_instr", k), instr_d, word_of(RPC + 32'(4 * k)));
      check1($sformatf("seq%0d_gap", k), bus.imem_req, 1'b0);
      tick();
    end

    // Three-cycle memory at 0x200: address held across the whole wait.
    do_reset(3, 1'b0);
    wait_resp("lat_first", 10);
    pcsrc    = 1'b1;
    pctarget = 32'h200;
    tick();
    pcsrc = 1'b0;
    check1("lat_gap", bus.imem_req, 1'b0);
    tick();
    for (int k = 0; k < 3; k++) begin
      check1($sformatf("lat%0d_req", k), bus.imem_req, 1'b1);
      check($sformatf("lat%0d_addr", k), bus.imem_addr, 32'h200);
      tick();
    end
    check("lat_instr", instr_d, word_of(32'h200));
    check("lat_pc", pc_d, 32'h200);

    // Stall when the response arrives: hold buffer, then release.
    do_reset(1, 1'b0);
    tick();
    stall = 1'b1;
    tick();
    check("hold_addr", bus.imem_addr, RPC + 32'd4);
    check1("hold_rq", bus.imem_req, 1'b1);
    tick();
    check1("hold_req0", bus.imem_req, 1'b0);
    check("hold_instr0", instr_d, word_of(RPC));
    tick();
    check1("hold_req1", bus.imem_req, 1'b0);
    check1("hold_valid1", valid_d, 1'b1);
    check("hold_pc1", pc_d, RPC);
    stall = 1'b0;
    tick();
    check("hold_rel_instr", instr_d, word_of(RPC + 32'd4));
    check("hold_rel_pc", pc_d, RPC + 32'd4);
    check1("hold_rel_req", bus.imem_req, 1'b1);
    check("hold_rel_addr", bus.imem_addr, RPC + 32'd8);

    // Redirect while waiting: stale response dropped, refetch at 0x400.
    do_reset(4, 1'b0);
    check1("drop_req0", bus.imem_req, 1'b1);
    pcsrc    = 1'b1;
    pctarget = 32'h400;
    tick();
    pcsrc = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (bus.imem_req) break;
      check1("drop_valid", valid_d, 1'b0);
      tick();
    end
    check1("drop_req", bus.imem_req, 1'b1);
    check("drop_addr", bus.imem_addr, 32'h400);
    wait_resp("drop_resp", 10);
    tick();
    check("drop_instr", instr_d, word_of(32'h400));
    check1("drop_valid_new", valid_d, 1'b1);

    // Address wrap: PC+4 of 0xFFFF_FFFC is 0.
    do_reset(1, 1'b0);
    pcsrc    = 1'b1;
    pctarget = 32'hFFFF_FFFC;
    tick();
    pcsrc = 1'b0;
    wait_req("wrap_req", 10);
    check("wrap_addr", bus.imem_addr, 32'hFFFF_FFFC);
    tick();
    check("wrap_pc4", pcplus4_d, 32'h0);
    wait_req("wrap_nreq", 10);
    check("wrap_naddr", bus.imem_addr, 32'h0);

    // Misaligned redirect target.
    do_reset(1, 1'b0);
    pcsrc    = 1'b1;
    pctarget = 32'h402;
    tick();
    pcsrc = 1'b0;
`ifdef FETCH_MISALIGN_EN
    check1("mis_flag", misalign, 1'b1);
    check1("mis_valid", valid_d, 1'b0);
    for (int i = 0; i < 6; i++) begin
      check1("mis_noreq", bus.imem_req, 1'b0);
      check1("mis_sticky", misalign, 1'b1);
      tick();
    end
    do_reset(1, 1'b0);
    check1("mis_clear", misalign, 1'b0);
    check1("mis_restart", bus.imem_req, 1'b1);
`else
    check1("mis_flag", misalign, 1'b0);
    wait_req("mis_req", 10);
    check("mis_addr", bus.imem_addr, 32'h400);
`endif

    // Randomized traffic against the behavioural model.
    do_reset(1, 1'b1);
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      bit rq;
      rq = !reset && model_req();
      check1("rnd_req", bus.imem_req, rq);
      if (rq) check("rnd_addr", bus.imem_addr, r_pc);
      check1("rnd_valid", valid_d, e_valid);
      check("rnd_instr", instr_d, e_instr);
      check("rnd_pc", pc_d, e_pc);
      check("rnd_pc4", pcplus4_d, e_pc4);
      check1("rnd_misalign", misalign, 1'b0);
      if (n_fail > 20) break;
      reset    = ($urandom_range(63) == 0);
      stall    = ($urandom_range(3) == 0);
      flush    = ($urandom_range(9) == 0);
      pcsrc    = ($urandom_range(7) == 0);
      pctarget = $urandom & 32'h0000_FFFC;
      #1;
      if (reset) model_reset();
      else model_step(bus.imem_valid, bus.imem_rdata);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
